// File: rtl/int_timer.sv
// Programmable interval timer with a sticky interrupt flag, programmed over the
// CPU data bus (CTRL/PRESET/COUNT window plus a separate acknowledge word).
module int_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h7f00,
    parameter logic [31:0] ACK_ADDR  = 32'h7f20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    localparam logic [29:0] CTRL_WA   = BASE_ADDR[31:2];
    localparam logic [29:0] PRESET_WA = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0] COUNT_WA  = BASE_ADDR[31:2] + 30'd2;
    localparam logic [29:0] ACK_WA    = ACK_ADDR[31:2];

    state_t      state_reg, state_next;
    logic [3:0]  ctrl_reg, ctrl_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        pending_reg, pending_next;

    logic [29:0] word_addr;
    logic        addr_unused;
    logic        wr_en;
    logic        sel_ctrl, sel_preset, sel_count;
    logic        ctrl_wr, preset_wr, ack_wr;
    logic [31:0] wmask;
    logic [3:0]  ctrl_wval;
    logic [31:0] preset_wval;
    logic        pend_set;

    logic       ctrl_en, ctrl_im;
    logic [1:0] ctrl_mode;

    assign word_addr   = addr[31:2];
    assign addr_unused = ^addr[1:0];
    assign wr_en       = |byteen;

    assign sel_ctrl   = (word_addr == CTRL_WA);
    assign sel_preset = (word_addr == PRESET_WA);
    assign sel_count  = (word_addr == COUNT_WA);

    assign ctrl_wr   = wr_en && sel_ctrl;
    assign preset_wr = wr_en && sel_preset;
    assign ack_wr    = wr_en && (word_addr == ACK_WA);

    // Expand byte enables into a bit mask for the read-modify-write merge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign wmask[gi*8 +: 8] = {8{byteen[gi]}};
    end

    assign ctrl_wval   = (ctrl_reg & ~wmask[3:0]) | (wdata[3:0] & wmask[3:0]);
    assign preset_wval = (preset_reg & ~wmask) | (wdata & wmask);

    assign ctrl_en   = ctrl_reg[0];
    assign ctrl_mode = ctrl_reg[2:1];
    assign ctrl_im   = ctrl_reg[3];

    always_comb begin
        state_next   = state_reg;
        ctrl_next    = ctrl_reg;
        preset_next  = preset_reg;
        count_next   = count_reg;
        pending_next = pending_reg;
        pend_set     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ctrl_en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                count_next = preset_reg;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en)               state_next = ST_IDLE;
                else if (count_reg == 32'd0) state_next = ST_INT;
                else                         count_next = count_reg - 32'd1;
            end
            ST_INT: begin
                pend_set = ctrl_im;
                if (ctrl_mode == 2'd1) begin
                    state_next = ST_LOAD;
                end else begin
                    ctrl_next[0] = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // CPU stores override the hardware EN clear taken in ST_INT.
        if (ctrl_wr)   ctrl_next   = ctrl_wval;
        if (preset_wr) preset_next = preset_wval;

        if (ack_wr || (ctrl_wr && !ctrl_wval[3])) pending_next = 1'b0;
        if (pend_set)                             pending_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            ctrl_reg    <= 4'd0;
            preset_reg  <= 32'd0;
            count_reg   <= 32'd0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ctrl_reg    <= ctrl_next;
            preset_reg  <= preset_next;
            count_reg   <= count_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel_ctrl)        rdata = {28'd0, ctrl_reg};
        else if (sel_preset) rdata = preset_reg;
        else if (sel_count)  rdata = count_reg;
    end

    assign irq = pending_reg;

endmodule

// File: tb/tb_int_timer.sv
// Directed bench for int_timer: inputs driven and outputs sampled on the falling
// clock edge; each comparison is an immediate assertion.
module tb_int_timer;

    localparam logic [31:0] A_CTRL   = 32'h7f00;
    localparam logic [31:0] A_PRESET = 32'h7f04;
    localparam logic [31:0] A_COUNT  = 32'h7f08;
    localparam logic [31:0] A_HOLE   = 32'h7f0c;
    localparam logic [31:0] A_ACK    = 32'h7f20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  byteen = 4'd0;
    logic [31:0] rdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    int_timer #(
        .BASE_ADDR(32'h7f00),
        .ACK_ADDR (32'h7f20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .byteen(byteen),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; the store is sampled by the next rising edge and
    // the task returns on the falling edge right after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(negedge clk);
        byteen = 4'd0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        logic [31:0] v;
        logic        seen_three;

        // Reset
        reset = 1'b1;
        #2 reset = 1'b0;
        step(2);
        check("rst_irq", {31'd0, irq}, 32'd0);
        chk_rd("rst_ctrl", A_CTRL, 32'd0);
        chk_rd("rst_preset", A_PRESET, 32'd0);
        chk_rd("rst_count", A_COUNT, 32'd0);
        reset = 1'b1;
        step(1);

        // Byte enables, read-only COUNT, unmapped reads
        wr(A_PRESET, 32'h11223344, 4'hF);
        wr(A_PRESET, 32'hAABBCCDD, 4'b0110);
        chk_rd("preset_be", A_PRESET, 32'h11BBCC44);
        wr(A_COUNT, 32'hFFFFFFFF, 4'hF);
        chk_rd("count_ro", A_COUNT, 32'd0);
        wr(A_CTRL, 32'hFFFFFFFF, 4'b1110);
        chk_rd("ctrl_be_upper", A_CTRL, 32'd0);
        chk_rd("rd_hole", A_HOLE, 32'd0);
        chk_rd("rd_ack", A_ACK, 32'd0);

        // One-shot PRESET=5: LOAD t+1, COUNT 5..0 at t+2..t+7, INT t+8, irq t+9
        wr(A_PRESET, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        step(1);
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk_rd($sformatf("oneshot_count%0d", k), A_COUNT, 32'd5 - 32'(k));
        end
        check("oneshot_irq_t7", {31'd0, irq}, 32'd0);
        step(1);
        check("oneshot_irq_int", {31'd0, irq}, 32'd0);
        step(1);
        check("oneshot_irq_rise", {31'd0, irq}, 32'd1);
        chk_rd("oneshot_ctrl_en_clr", A_CTRL, 32'h8);
        step(3);
        check("oneshot_irq_sticky", {31'd0, irq}, 32'd1);
        wr(A_ACK, 32'hDEADBEEF, 4'b0001);
        check("oneshot_ack", {31'd0, irq}, 32'd0);

        // Stop at COUNT=6 and resume
        wr(A_PRESET, 32'd10, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        step(5);
        wr(A_CTRL, 32'h8, 4'hF);
        chk_rd("stop_count", A_COUNT, 32'd6);
        step(3);
        chk_rd("stop_hold", A_COUNT, 32'd6);
        check("stop_irq", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h9, 4'hF);
        chk_rd("resume_t0", A_COUNT, 32'd6);
        step(1);
        chk_rd("resume_load", A_COUNT, 32'd6);
        step(1);
        chk_rd("resume_reload", A_COUNT, 32'd10);
        wr(A_CTRL, 32'h0, 4'hF);

        // Auto-reload PRESET=2: INT at t+5, t+10; irq at t+6, t+11
        wr(A_PRESET, 32'd2, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        step(5);
        check("reload_irq_int", {31'd0, irq}, 32'd0);
        step(1);
        check("reload_irq_rise1", {31'd0, irq}, 32'd1);
        wr(A_ACK, 32'd0, 4'b0001);
        check("reload_ack", {31'd0, irq}, 32'd0);
        chk_rd("reload_count", A_COUNT, 32'd2);
        step(3);
        check("reload_irq_t10", {31'd0, irq}, 32'd0);
        step(1);
        check("reload_irq_rise2", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h0, 4'hF);
        check("ctrl_im0_clear", {31'd0, irq}, 32'd0);
        wr(A_PRESET, 32'd0, 4'hF);

        // PRESET=0 MODE 1: INT occupies the cycle before edges s+4, s+7, ...
        wr(A_CTRL, 32'hB, 4'hF);
        step(3);
        wr(A_ACK, 32'd0, 4'b0001);
        check("collision_set_wins", {31'd0, irq}, 32'd1);
        wr(A_ACK, 32'd0, 4'b0001);
        check("collision_ack_after", {31'd0, irq}, 32'd0);
        step(1);
        check("collision_irq_int", {31'd0, irq}, 32'd0);
        step(1);
        check("collision_irq_rise", {31'd0, irq}, 32'd1);

        // Masking: IM=0 clears irq and keeps it low while MODE 1 keeps running
        wr(A_CTRL, 32'h3, 4'hF);
        check("mask_clear", {31'd0, irq}, 32'd0);
        wr(A_PRESET, 32'd3, 4'hF);
        seen_three = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            addr = A_COUNT;
            #1;
            v = rdata;
            if (v == 32'd3) seen_three = 1'b1;
            check($sformatf("mask_irq%0d", k), {31'd0, irq}, 32'd0);
        end
        check("mask_counting", {31'd0, seen_three}, 32'd1);
        chk_rd("mask_ctrl", A_CTRL, 32'h3);

        // Mid-operation reset with irq asserted
        wr(A_CTRL, 32'hB, 4'hF);
        step(8);
        check("prereset_irq", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        #1;
        check("reset_async_irq", {31'd0, irq}, 32'd0);
        step(2);
        chk_rd("midrst_ctrl", A_CTRL, 32'd0);
        chk_rd("midrst_preset", A_PRESET, 32'd0);
        chk_rd("midrst_count", A_COUNT, 32'd0);
        reset = 1'b1;
        step(1);
        check("postrst_irq", {31'd0, irq}, 32'd0);
        chk_rd("postrst_count", A_COUNT, 32'd0);

        // From IDLE after reset: one-shot with IM=0 reloads on time and stays quiet
        wr(A_PRESET, 32'd4, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        step(2);
        chk_rd("postrst_load", A_COUNT, 32'd4);
        step(6);
        chk_rd("noim_ctrl", A_CTRL, 32'd0);
        check("noim_irq", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
